dmem_responder: RTL
===================

# dmem_responder

Handshaked data-memory responder serving the processor's load/store port. It accepts one request at a time over a valid/ready channel and models a fixed multi-cycle memory latency. It performs RV32I byte/half/word accesses with sign or zero extension, and returns data or an error over a second valid/ready channel. It replaces the zero-latency combinational data memory when the core is moved to a stalling memory interface.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; power of two, 4..4096.
- LATENCY, 2: cycles spent in WAIT per request; integer 1..15.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_f3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request rejected: misaligned, out of range, or illegal funct3.

## Operation
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - latch write, f3, addr, wdata;
    - load the counter with LATENCY-1;
    - go to WAIT.
  - WAIT: req_ready=0. If counter≠0, decrement. If counter==0:
    - perform the access;
    - register rsp_rdata and rsp_err;
    - go to RESP.
  - RESP: rsp_valid=1. Outputs stay stable until rsp_ready=1. Then go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Legal loads:
  - f3=000 LB: sign-extend byte.
  - f3=001 LH: sign-extend half.
  - f3=010 LW.
  - f3=100 LBU: zero-extend byte.
  - f3=101 LHU: zero-extend half.
- Legal stores:
  - f3=000 SB: wdata[7:0].
  - f3=001 SH: wdata[15:0].
  - f3=010 SW.
- Any other f3 is an error.
- Byte lane select:
  - addr[1:0] selects the byte lane.
  - addr[1] selects the half lane.
  - Word index = addr[31:2].
- Memory is little-endian; byte 0 is bits [7:0].
- Error conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH;
  - illegal f3.
- On error: no memory write, rsp_rdata=0, rsp_err=1.
- Stores modify only the selected byte lanes; the other lanes are preserved.
- A store response has rsp_rdata=0 and rsp_err=0.
- Request inputs are ignored outside an IDLE handshake; only the latched copies are used.

## Timing
- Reset values:
  - state=IDLE, counter=0;
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - all DEPTH words cleared to 0 during the reset cycle.
- Request accepted at clock edge E. rsp_valid first goes high after edge E+LATENCY; that edge also commits any store.
- Minimum occupancy is LATENCY+2 cycles per request:
  - req_ready returns to 1 the cycle after the response handshake;
  - no accept in the same cycle as a response handshake.
- rsp_ready held low keeps RESP indefinitely with stable outputs.
- rsp_ready high before RESP has no effect.
- rst during WAIT or RESP:
  - return to IDLE next edge;
  - drop the pending response;
  - an uncommitted store is discarded.
- rst overrides every other input in the same cycle.
- Memory reads and writes use the latched request only. No combinational path from req_* to rsp_*.

## Test plan
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10, LATENCY=2, rsp_ready=1 -> load rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises exactly 2 edges after each accept.
- SB addr=0x21 wdata=0x80 over a zeroed word -> LW 0x20 returns 0x00008000; LB 0x21 returns 0xFFFFFF80; LBU 0x21 returns 0x00000080.
- SH addr=0x32 wdata=0x1234ABCD over SW 0x30=0x11111111 -> LW 0x30 returns 0xABCD1111; LH 0x32 returns 0xFFFFABCD; LHU 0x32 returns 0x0000ABCD.
- Error cases, each -> rsp_err=1, rsp_rdata=0:
  - LW addr=0x13;
  - SH addr=0x15;
  - LW addr=DEPTH*4;
  - f3=011.
  - A following LW of the touched words shows no change.
- Response backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; after handshake, req_ready=1 the next cycle.
- SW 0x40=0x5 issued, rst asserted during WAIT -> outputs at reset values next cycle; LW 0x40 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked RV32I data-memory responder with a fixed multi-cycle latency.
// One request is in flight at a time; loads are extended and stores are byte-lane masked.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [AW-1:0]     widx_c;
  logic [31:0]       word_c;
  logic [31:0]       shifted_c;
  logic [31:0]       load_c;
  logic [31:0]       merged_c;
  logic [31:0]       lane_data_c;
  logic [3:0]        be_c;
  logic              legal_f3_c;
  logic              misalign_c;
  logic              range_c;
  logic              err_c;
  logic              mem_we_c;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Access decode works only from the latched request copy.
  assign widx_c    = addr_q[AW+1:2];
  assign word_c    = mem_q[widx_c];
  assign shifted_c = word_c >> {addr_q[1:0], 3'b000};

  always_comb begin
    legal_f3_c = 1'b0;
    misalign_c = 1'b0;
    if (wr_q) begin
      legal_f3_c = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    end else begin
      legal_f3_c = (f3_q != 3'b011) && (f3_q != 3'b110) && (f3_q != 3'b111);
    end
    case (f3_q[1:0])
      2'b01:   misalign_c = addr_q[0];
      2'b10:   misalign_c = (addr_q[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
    range_c = ((addr_q >> (AW + 2)) != 32'd0);
    err_c   = !legal_f3_c || misalign_c || range_c;
  end

  always_comb begin
    load_c = 32'd0;
    case (f3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'd0, shifted_c[7:0]};
      3'b101:  load_c = {16'd0, shifted_c[15:0]};
      default: load_c = 32'd0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    be_c        = 4'b1111;
    lane_data_c = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be_c        = 4'b0001 << addr_q[1:0];
        lane_data_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c        = 4'b1111;
        lane_data_c = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_c[8*i +: 8] = be_c[i] ? lane_data_c[8*i +: 8] : word_c[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d        = req_write;
          f3_d        = req_f3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CW'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mem_we_c    = wr_q && !err_c;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (err_c || wr_q) ? 32'd0 : load_c;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Whole array clears in the reset cycle; a store commits on the WAIT exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we_c) begin
      mem_q[widx_c] <= merged_c;
    end
  end

endmodule
